arm_fetch: RTL

Instruction fetch stage directly upstream of the instruction decoder. It owns the fetch PC, issues single-outstanding word reads to instruction memory over a req/ack handshake, and latches the returned word into an instruction register. The decoder consumes that register through a valid/ready handshake. Branch redirects from the register-file PC write path (pc_we/pc_in) flush the instruction register and any in-flight fetch.

---
 rtl/arm_fetch_if.sv | 25 ++
 rtl/arm_fetch.sv | 113 +++++++++++
 2 files changed

// File: rtl/arm_fetch_if.sv
// Fetch-stage bus bundle: instruction memory port, decoder port and redirect input.
// Carries no state; latency and backpressure are defined by the fetch stage.
// Master is the fetch stage; slave is the memory/decoder/branch side.
interface arm_fetch_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic [31:0] inst;
   logic [31:0] inst_pc;
   logic        inst_valid;
   logic        decode_ready;
   logic        pc_we;
   logic [31:0] pc_in;

   modport master (
      output imem_req, imem_addr, inst, inst_pc, inst_valid,
      input  imem_ack, imem_rdata, decode_ready, pc_we, pc_in
   );

   modport slave (
      input  imem_req, imem_addr, inst, inst_pc, inst_valid,
      output imem_ack, imem_rdata, decode_ready, pc_we, pc_in
   );
endinterface

// File: rtl/arm_fetch.sv
// Instruction fetch: single-outstanding imem reads into an instruction register for the decoder.
// Latency: ack at N -> inst_valid at N+1; decoder accept at M -> next imem_req at M+1.
// Backpressure: decode_ready low parks the word in HOLD with no request; redirects flush it.
module arm_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic       clk,
   input  logic       reset,
   arm_fetch_if.master bus
);

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      HOLD  = 2'd1,
      DRAIN = 2'd2
   } state_t;

   state_t      state, state_nxt;
   logic [31:0] pc, pc_nxt;
   logic [31:0] req_addr, req_addr_nxt;
   logic [31:0] inst_q, inst_nxt;
   logic [31:0] inst_pc_q, inst_pc_nxt;
   logic        inst_valid_q, inst_valid_nxt;
   logic [31:0] redirect_pc;
   logic        unused_pc_lsbs;

   // Redirect targets are always word aligned; the low bits carry no meaning.
   assign redirect_pc    = {bus.pc_in[31:2], 2'b00};
   assign unused_pc_lsbs = ^bus.pc_in[1:0];

   assign bus.imem_req   = ((state == FETCH) || (state == DRAIN)) && !reset;
   assign bus.imem_addr  = req_addr;
   assign bus.inst       = inst_q;
   assign bus.inst_pc    = inst_pc_q;
   assign bus.inst_valid = inst_valid_q;

   // State register.
   always_ff @(posedge clk) begin
      if (reset) state <= FETCH;
      else       state <= state_nxt;
   end

   // Datapath registers: fetch PC, outstanding address and the instruction register.
   always_ff @(posedge clk) begin
      if (reset) begin
         pc           <= RESET_PC;
         req_addr     <= RESET_PC;
         inst_q       <= 32'h0;
         inst_pc_q    <= 32'h0;
         inst_valid_q <= 1'b0;
      end else begin
         pc           <= pc_nxt;
         req_addr     <= req_addr_nxt;
         inst_q       <= inst_nxt;
         inst_pc_q    <= inst_pc_nxt;
         inst_valid_q <= inst_valid_nxt;
      end
   end

   // Next-state and next-register logic; a redirect always beats a returning word.
   always_comb begin
      state_nxt      = state;
      pc_nxt         = pc;
      req_addr_nxt   = req_addr;
      inst_nxt       = inst_q;
      inst_pc_nxt    = inst_pc_q;
      inst_valid_nxt = inst_valid_q;
      case (state)
         FETCH: begin
            if (bus.pc_we && bus.imem_ack) begin
               // Request completed, so the new address can go out right away.
               pc_nxt       = redirect_pc;
               req_addr_nxt = redirect_pc;
            end else if (bus.pc_we) begin
               // Address must stay stable until the memory acks; drain it first.
               pc_nxt    = redirect_pc;
               state_nxt = DRAIN;
            end else if (bus.imem_ack) begin
               inst_nxt       = bus.imem_rdata;
               inst_pc_nxt    = req_addr;
               inst_valid_nxt = 1'b1;
               pc_nxt         = req_addr + 32'd4;
               state_nxt      = HOLD;
            end
         end
         HOLD: begin
            if (bus.pc_we) begin
               inst_valid_nxt = 1'b0;
               pc_nxt         = redirect_pc;
               req_addr_nxt   = redirect_pc;
               state_nxt      = FETCH;
            end else if (bus.decode_ready) begin
               inst_valid_nxt = 1'b0;
               req_addr_nxt   = pc;
               state_nxt      = FETCH;
            end
         end
         DRAIN: begin
            // Stale word is dropped; the latest redirect target wins.
            if (bus.pc_we) pc_nxt = redirect_pc;
            if (bus.imem_ack) begin
               req_addr_nxt = bus.pc_we ? redirect_pc : pc;
               state_nxt    = FETCH;
            end
         end
         default: begin
            state_nxt      = FETCH;
            inst_valid_nxt = 1'b0;
         end
      endcase
   end

endmodule
